// File: rtl/load_store_unit_if.sv
// Load/store bus bundle: pipeline request/response side plus word-wide DataMemory side.
// Latency: none, wiring only.
// Backpressure: req_ready from the unit; responses and memory strobes are not backpressured.
interface load_store_unit_if;
  // pipeline request side
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // pipeline response side
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  // DataMemory side
  logic [31:0] address;
  logic [31:0] writeData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] readData;

  // the load/store unit itself
  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, readData,
    output req_ready, resp_valid, resp_rdata, resp_err, address, writeData, MemRead, MemWrite
  );

  // the pipeline stage and memory model around the unit
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, readData,
    input  req_ready, resp_valid, resp_rdata, resp_err, address, writeData, MemRead, MemWrite
  );
endinterface

// File: rtl/load_store_unit.sv
// Sequences byte/halfword/word loads and stores onto a word-wide memory; sub-word stores are read-modify-write.
// Latency: load READ_LATENCY+1, word store 2, sub-word store READ_LATENCY+2 cycles from accept to resp_valid.
// Backpressure: req_ready only in IDLE, one access in flight; no response backpressure. Option macro: LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int READ_LATENCY = 1
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave lsu
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam int            CW       = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(READ_LATENCY - 1);

  // FSM state and read-latency counter
  state_t      r_state;
  state_t      w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  // captured request fields
  logic        r_write;
  logic        r_signed;
  logic [1:0]  r_size;
  logic [1:0]  r_lane;
  logic [15:0] r_wdata;

  // registered outputs
  logic        r_mem_read;
  logic        r_mem_write;
  logic [31:0] r_address;
  logic [31:0] r_write_data;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;

  // combinational helpers
  logic        w_misalign;
  logic [31:0] w_req_addr;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ld_ext;
  logic [31:0] w_merged;
  logic [31:0] w_address_nxt;
  logic [31:0] w_wdata_nxt;
  logic [31:0] w_rdata_nxt;
  logic        w_err_nxt;

  assign lsu.req_ready  = (r_state == IDLE);
  assign lsu.MemRead    = r_mem_read;
  assign lsu.MemWrite   = r_mem_write;
  assign lsu.address    = r_address;
  assign lsu.writeData  = r_write_data;
  assign lsu.resp_valid = r_resp_valid;
  assign lsu.resp_rdata = r_resp_rdata;
  assign lsu.resp_err   = r_resp_err;

`ifdef LSU_MISALIGN_TRAP_EN
  // misaligned halfword/word requests are trapped and answered with an error
  always_comb begin
    w_misalign = ((lsu.req_size == 2'b01) && lsu.req_addr[0]) ||
                 (lsu.req_size[1] && (lsu.req_addr[1:0] != 2'b00));
    w_req_addr = lsu.req_addr;
  end
`else
  // misaligned halfword/word requests are silently aligned down and proceed
  always_comb begin
    w_misalign = 1'b0;
    w_req_addr = lsu.req_addr;
    if (lsu.req_size[1]) begin
      w_req_addr[1:0] = 2'b00;
    end else if (lsu.req_size == 2'b01) begin
      w_req_addr[0] = 1'b0;
    end
  end
`endif

  // lane extraction, load extension and store merge on the word coming back from memory
  always_comb begin
    w_byte = lsu.readData[7:0];
    case (r_lane)
      2'd1:    w_byte = lsu.readData[15:8];
      2'd2:    w_byte = lsu.readData[23:16];
      2'd3:    w_byte = lsu.readData[31:24];
      default: w_byte = lsu.readData[7:0];
    endcase
    w_half = r_lane[1] ? lsu.readData[31:16] : lsu.readData[15:0];

    w_ld_ext = lsu.readData;
    if (r_size == 2'b00) begin
      w_ld_ext = {{24{r_signed & w_byte[7]}}, w_byte};
    end else if (r_size == 2'b01) begin
      w_ld_ext = {{16{r_signed & w_half[15]}}, w_half};
    end

    w_merged = lsu.readData;
    if (r_size == 2'b00) begin
      case (r_lane)
        2'd1:    w_merged[15:8]  = r_wdata[7:0];
        2'd2:    w_merged[23:16] = r_wdata[7:0];
        2'd3:    w_merged[31:24] = r_wdata[7:0];
        default: w_merged[7:0]   = r_wdata[7:0];
      endcase
    end else if (r_size == 2'b01) begin
      if (r_lane[1]) begin
        w_merged[31:16] = r_wdata;
      end else begin
        w_merged[15:0] = r_wdata;
      end
    end
  end

  // next-state and next-output decode
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_address_nxt = r_address;
    w_wdata_nxt   = r_write_data;
    w_rdata_nxt   = r_resp_rdata;
    w_err_nxt     = r_resp_err;
    case (r_state)
      IDLE: begin
        if (lsu.req_valid) begin
          w_address_nxt = {2'b00, w_req_addr[31:2]};
          w_cnt_nxt     = '0;
          w_rdata_nxt   = '0;
          w_err_nxt     = 1'b0;
          if (w_misalign) begin
            w_state_nxt = RESP;
            w_err_nxt   = 1'b1;
          end else if (lsu.req_write && lsu.req_size[1]) begin
            w_state_nxt = WR;
            w_wdata_nxt = lsu.req_wdata;
          end else begin
            w_state_nxt = RD;
          end
        end
      end
      RD: begin
        if (r_cnt == CNT_LAST) begin
          if (r_write) begin
            w_state_nxt = WR;
            w_wdata_nxt = w_merged;
          end else begin
            w_state_nxt = RESP;
            w_rdata_nxt = w_ld_ext;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      WR:      w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // counter, captured request and registered outputs; strobes follow the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_write      <= 1'b0;
      r_signed     <= 1'b0;
      r_size       <= 2'b00;
      r_lane       <= 2'b00;
      r_wdata      <= '0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_address    <= '0;
      r_write_data <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      if ((r_state == IDLE) && lsu.req_valid) begin
        r_write  <= lsu.req_write;
        r_signed <= lsu.req_signed;
        r_size   <= lsu.req_size;
        r_lane   <= w_req_addr[1:0];
        r_wdata  <= lsu.req_wdata[15:0];
      end
      r_cnt        <= w_cnt_nxt;
      r_mem_read   <= (w_state_nxt == RD);
      r_mem_write  <= (w_state_nxt == WR);
      r_resp_valid <= (w_state_nxt == RESP);
      r_address    <= w_address_nxt;
      r_write_data <= w_wdata_nxt;
      r_resp_rdata <= w_rdata_nxt;
      r_resp_err   <= w_err_nxt;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: L=1 and L=3 instances, each with a small word memory model.
// Expected responses and writes are queued at issue time and compared when the DUT produces them.
// Honours LSU_MISALIGN_TRAP_EN for the misaligned-load expectation.
module tb_load_store_unit;

  typedef struct {
    logic [31:0] dat;
    logic        err;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] dat;
    int          cyc;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   acc = 0;
  int   acc_b = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  rsp_t rq_a[$];
  wr_t  wq_a[$];
  rsp_t rq_b[$];
  rsp_t ea;
  wr_t  wa;
  rsp_t eb;

  logic [31:0] mem_a [0:63];
  logic [31:0] mem_b [0:63];

  load_store_unit_if ifa ();
  load_store_unit_if ifb ();

  load_store_unit #(.READ_LATENCY(1)) u_dut_a (.clk(clk), .rst_n(rst_n), .lsu(ifa));
  load_store_unit #(.READ_LATENCY(3)) u_dut_b (.clk(clk), .rst_n(rst_n), .lsu(ifb));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // word memories
  assign ifa.readData = mem_a[ifa.address[5:0]];
  assign ifb.readData = mem_b[ifb.address[5:0]];
  always @(posedge clk) begin
    if (ifa.MemWrite) mem_a[ifa.address[5:0]] <= ifa.writeData;
    if (ifb.MemWrite) mem_b[ifb.address[5:0]] <= ifb.writeData;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // waits for idle on DUT A, presents one request for one cycle, leaves acc = cycle count after accept
  task automatic issue_a(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] ad, input logic [31:0] wd);
    int t;
    t = 0;
    @(negedge clk);
    while (!ifa.req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("a_ready_wait", 32'(ifa.req_ready), 32'd1);
    ifa.req_valid  = 1'b1;
    ifa.req_write  = wr;
    ifa.req_size   = sz;
    ifa.req_signed = sg;
    ifa.req_addr   = ad;
    ifa.req_wdata  = wd;
    @(posedge clk);
    #1;
    ifa.req_valid = 1'b0;
    acc = cyc;
  endtask

  // cycle n after the accepting edge shows cyc == acc + n - 1
  task automatic exp_rsp_a(input logic [31:0] dat, input logic err, input int cycle_n);
    rq_a.push_back('{dat, err, acc + cycle_n - 1});
  endtask

  task automatic exp_wr_a(input logic [31:0] addr, input logic [31:0] dat, input int cycle_n);
    wq_a.push_back('{addr, dat, acc + cycle_n - 1});
  endtask

  // response / write scoreboard for DUT A
  always @(negedge clk) begin
    if (ifa.resp_valid) begin
      if (rq_a.size() == 0) begin
        chk("a_resp_spurious", 32'(ifa.resp_valid), 32'd0);
      end else begin
        ea = rq_a.pop_front();
        chk("a_resp_rdata", ifa.resp_rdata, ea.dat);
        chk("a_resp_err", 32'(ifa.resp_err), 32'(ea.err));
        chk("a_resp_cycle", 32'(cyc), 32'(ea.cyc));
      end
    end
    if (ifa.MemWrite) begin
      if (wq_a.size() == 0) begin
        chk("a_write_spurious", 32'(ifa.MemWrite), 32'd0);
      end else begin
        wa = wq_a.pop_front();
        chk("a_write_address", ifa.address, wa.addr);
        chk("a_write_data", ifa.writeData, wa.dat);
        chk("a_write_cycle", 32'(cyc), 32'(wa.cyc));
      end
    end
    if (ifa.MemRead || ifa.MemWrite) begin
      chk("a_strobe_exclusive", 32'(ifa.MemRead & ifa.MemWrite), 32'd0);
    end
  end

  // response scoreboard for DUT B
  always @(negedge clk) begin
    if (ifb.resp_valid) begin
      if (rq_b.size() == 0) begin
        chk("b_resp_spurious", 32'(ifb.resp_valid), 32'd0);
      end else begin
        eb = rq_b.pop_front();
        chk("b_resp_rdata", ifb.resp_rdata, eb.dat);
        chk("b_resp_cycle", 32'(cyc), 32'(eb.cyc));
      end
    end
  end

  initial begin
    ifa.req_valid = 1'b0; ifa.req_write = 1'b0; ifa.req_size = 2'b00; ifa.req_signed = 1'b0;
    ifa.req_addr = '0; ifa.req_wdata = '0;
    ifb.req_valid = 1'b0; ifb.req_write = 1'b0; ifb.req_size = 2'b00; ifb.req_signed = 1'b0;
    ifb.req_addr = '0; ifb.req_wdata = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_memread", 32'(ifa.MemRead), 32'd0);
    chk("rst_memwrite", 32'(ifa.MemWrite), 32'd0);
    chk("rst_resp_valid", 32'(ifa.resp_valid), 32'd0);
    chk("rst_resp_err", 32'(ifa.resp_err), 32'd0);
    chk("rst_address", ifa.address, 32'd0);
    chk("rst_writedata", ifa.writeData, 32'd0);
    chk("rst_resp_rdata", ifa.resp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(ifa.req_ready), 32'd1);

    // word store: MemWrite cycle 1, resp cycle 2, ready again cycle 3
    issue_a(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    exp_wr_a(32'd4, 32'hDEADBEEF, 1);
    exp_rsp_a(32'h0, 1'b0, 2);
    chk("st_ready_c1", 32'(ifa.req_ready), 32'd0);
    @(posedge clk); #1;
    chk("st_ready_c2", 32'(ifa.req_ready), 32'd0);
    @(posedge clk); #1;
    chk("st_ready_c3", 32'(ifa.req_ready), 32'd1);

    // word load back
    issue_a(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    exp_rsp_a(32'hDEADBEEF, 1'b0, 2);
    chk("ld_memread_c1", 32'(ifa.MemRead), 32'd1);
    chk("ld_address_c1", ifa.address, 32'd4);

    // sub-word loads from 0x80FF7F01 @0x20
    issue_a(1'b1, 2'b10, 1'b0, 32'h20, 32'h80FF7F01);
    exp_wr_a(32'd8, 32'h80FF7F01, 1);
    exp_rsp_a(32'h0, 1'b0, 2);
    issue_a(1'b0, 2'b00, 1'b1, 32'h23, 32'h0);
    exp_rsp_a(32'hFFFFFF80, 1'b0, 2);
    issue_a(1'b0, 2'b00, 1'b0, 32'h23, 32'h0);
    exp_rsp_a(32'h00000080, 1'b0, 2);
    issue_a(1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
    exp_rsp_a(32'h00007F01, 1'b0, 2);
    issue_a(1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
    exp_rsp_a(32'hFFFF80FF, 1'b0, 2);
    issue_a(1'b0, 2'b00, 1'b1, 32'h21, 32'h0);
    exp_rsp_a(32'h0000007F, 1'b0, 2);

    // byte store into 0x11223344 @0x30, lane 2
    issue_a(1'b1, 2'b10, 1'b0, 32'h30, 32'h11223344);
    exp_wr_a(32'd12, 32'h11223344, 1);
    exp_rsp_a(32'h0, 1'b0, 2);
    issue_a(1'b1, 2'b00, 1'b0, 32'h32, 32'hFFFFFFAA);
    exp_wr_a(32'd12, 32'h11AA3344, 2);
    exp_rsp_a(32'h0, 1'b0, 3);
    chk("sb_memread_c1", 32'(ifa.MemRead), 32'd1);
    chk("sb_memwrite_c1", 32'(ifa.MemWrite), 32'd0);
    @(posedge clk); #1;
    chk("sb_memread_c2", 32'(ifa.MemRead), 32'd0);
    issue_a(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    exp_rsp_a(32'h11AA3344, 1'b0, 2);

    // halfword store into low half
    issue_a(1'b1, 2'b01, 1'b0, 32'h30, 32'h1234BEEF);
    exp_wr_a(32'd12, 32'h11AABEEF, 2);
    exp_rsp_a(32'h0, 1'b0, 3);
    issue_a(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    exp_rsp_a(32'h11AABEEF, 1'b0, 2);

    // misaligned word load @0x12
    issue_a(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    exp_rsp_a(32'h0, 1'b1, 1);
    chk("mis_memread_c1", 32'(ifa.MemRead), 32'd0);
`else
    exp_rsp_a(32'hDEADBEEF, 1'b0, 2);
    chk("mis_address_c1", ifa.address, 32'd4);
`endif

    // reset during the RD cycle of a byte store: no write, no response
    issue_a(1'b1, 2'b00, 1'b0, 32'h30, 32'h00000055);
    chk("rma_memread_c1", 32'(ifa.MemRead), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rma_memread_async", 32'(ifa.MemRead), 32'd0);
    chk("rma_address_async", ifa.address, 32'd0);
    chk("rma_resp_valid", 32'(ifa.resp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rma_ready_after", 32'(ifa.req_ready), 32'd1);
    issue_a(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    exp_rsp_a(32'h11AABEEF, 1'b0, 2);

    // READ_LATENCY=3: seed memory, then back-to-back requests with req_valid held high
    @(negedge clk);
    ifb.req_valid = 1'b1; ifb.req_write = 1'b1; ifb.req_size = 2'b10;
    ifb.req_addr = 32'h8; ifb.req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    ifb.req_valid = 1'b0;
    rq_b.push_back('{32'h0, 1'b0, cyc + 1});
    repeat (4) @(negedge clk);
    ifb.req_valid = 1'b1; ifb.req_write = 1'b0; ifb.req_size = 2'b10; ifb.req_signed = 1'b0;
    ifb.req_addr = 32'h8;
    @(posedge clk); #1;
    acc_b = cyc;
    rq_b.push_back('{32'hCAFEF00D, 1'b0, acc_b + 3});
    ifb.req_size = 2'b00; ifb.req_addr = 32'h9;
    for (int n = 1; n <= 3; n++) begin
      chk("b_memread_held", 32'(ifb.MemRead), 32'd1);
      chk("b_ready_busy", 32'(ifb.req_ready), 32'd0);
      @(posedge clk); #1;
    end
    chk("b_memread_c4", 32'(ifb.MemRead), 32'd0);
    chk("b_ready_c4", 32'(ifb.req_ready), 32'd0);
    @(posedge clk); #1;
    chk("b_ready_c5", 32'(ifb.req_ready), 32'd1);
    @(posedge clk); #1;
    ifb.req_valid = 1'b0;
    rq_b.push_back('{32'h000000F0, 1'b0, cyc + 3});
    chk("b_second_accept", 32'(ifb.MemRead), 32'd1);
    repeat (8) @(negedge clk);

    chk("a_resp_drained", 32'(rq_a.size()), 32'd0);
    chk("a_write_drained", 32'(wq_a.size()), 32'd0);
    chk("b_resp_drained", 32'(rq_b.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequences pipeline load/store requests onto the word-wide `DataMemory` port, and is the initiator that drives `address`, `writeData`, `MemRead` and `MemWrite`. It supports byte, halfword and word accesses, with sign or zero extension on loads. Sub-word stores are done as read-modify-write. It sits between the MEM stage and `DataMemory`, and it holds off the pipeline via `req_ready` while an access is in flight.

## Interface
- `READ_LATENCY`, default 1: number of cycles `MemRead` is held before `readData` is sampled (≥1).
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle and able to accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 = byte, 01 = halfword, 10 = word; 11 is treated as word.
- `req_signed` in 1: sign-extend loads. Ignored on stores.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data. 0 for stores.
- `resp_err` out 1: misaligned request, valid with `resp_valid`.
- `address` out 32: word index to memory, `{2'b00, addr[31:2]}`.
- `writeData` out 32: merged word to memory.
- `MemRead` out 1: memory read strobe.
- `MemWrite` out 1: memory write strobe, one cycle per write.
- `readData` in 32: memory read data.

## Operation
- **Byte order:** little-endian. Byte lane k is `readData[8k+7:8k]` and is selected by `addr[1:0]`. The halfword is selected by `addr[1]`.
- **Handshake:** a request is accepted on the edge where `req_valid && req_ready`. All request fields are captured into registers at that edge. `req_ready` = 1 only in IDLE.
- **FSM states:** IDLE, RD, WR, RESP.
- **IDLE:**
  - Load or sub-word store → RD.
  - Word store → WR.
  - Misaligned request (when checking is enabled) → RESP with error.
- **RD:**
  - `MemRead` = 1 and `address` is held for `READ_LATENCY` cycles, tracked by a counter.
  - On the final RD edge, `readData` is captured.
  - Load → RESP.
  - Sub-word store → WR. `writeData` = captured word with the target byte or halfword lanes replaced by the low bits of `req_wdata`.
- **WR:** `MemWrite` = 1 for exactly one cycle with `writeData` valid, then → RESP. `MemRead` = 0 in WR.
- **RESP:** `resp_valid` = 1 for one cycle, then → IDLE. There is no response backpressure.
- **Load extension:**
  - Byte: `{24{sign&b[7]}, b}`.
  - Halfword: `{16{sign&h[15]}, h}`.
  - Word: unchanged.
- `MemRead` and `MemWrite` are registered outputs and are never both 1 in the same cycle.
- **Reset values:** state IDLE; `req_ready` 1 (from the first cycle after reset deassertion); `MemRead`, `MemWrite`, `resp_valid`, `resp_err` 0; `address`, `writeData`, `resp_rdata` 0.
- **Reset mid-access:** all outputs return to reset values immediately (asynchronously). An interrupted RD→WR sequence produces no write. The request is dropped with no response.
- `req_valid` outside IDLE is ignored. It is not queued.

## Timing
- Edge numbering: edge 0 is the accepting edge. Cycle n is the cycle after edge n-1.
- **Word store:** `MemWrite` in cycle 1, `resp_valid` in cycle 2, `req_ready` in cycle 3.
- **Load:** `MemRead` in cycles 1..L (L = `READ_LATENCY`), capture at edge L, `resp_valid` in cycle L+1.
- **Sub-word store:** `MemRead` in cycles 1..L, `MemWrite` in cycle L+1, `resp_valid` in cycle L+2.
- **Error response:** `resp_valid` in cycle 1 with no memory strobe.
- Throughput is one access in flight at a time. The minimum request spacing is the latency plus 1 cycle.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- **Defined:**
  - Halfword with `addr[0]`=1, or word with `addr[1:0]`≠0, goes straight to RESP.
  - `resp_err` = 1, `resp_rdata` = 0, no memory access.
- **Undefined:**
  - Misaligned addresses are aligned down: halfword clears `addr[0]`, word clears `addr[1:0]`. The access then proceeds normally.
  - `resp_err` is tied to 0.

## Test plan
- **Word store then load (L=1):**
  - Store 0xDEADBEEF @0x10 → `MemWrite` one cycle with `address`=4, `writeData`=0xDEADBEEF.
  - Word load @0x10 → `resp_rdata`=0xDEADBEEF two cycles after accept.
- **Byte loads:** memory word 0x80FF7F01 @0x20:
  - Signed byte @0x23 → 0xFFFFFF80.
  - Unsigned byte @0x23 → 0x00000080.
  - Signed halfword @0x20 → 0x00007F01.
- **Sub-word store:** memory word 0x11223344, byte store 0xAA @addr[1:0]=2 → one `MemRead` cycle, then `MemWrite` with `writeData`=0x11AA3344, `resp_valid` in cycle 3.
- **Misaligned word load @0x12:**
  - With `LSU_MISALIGN_TRAP_EN`: `resp_err`=1 in cycle 1, no strobes.
  - Without it: reads word index 4.
- **Reset mid-access:** `rst_n` low during the RD cycle of a sub-word store → `MemRead` drops asynchronously, no `MemWrite` ever occurs, no `resp_valid`, and `req_ready`=1 after release.
- **READ_LATENCY=3 with back-to-back `req_valid`:** `MemRead` held 3 cycles, the second request is accepted only after `resp_valid` and on return to IDLE, and `req_ready`=0 throughout the first access.
